repeat_sub_divider: RTL and testbench
=====================================

Name: repeat_sub_divider

Overview:
Unsigned integer divider built as a datapath/controller pair that divides by repeated subtraction. It is the inverse companion of the team's repeated-addition multiplier. Like the multiplier, it loads both operands from one shared data_in bus on consecutive cycles after start. It returns quotient and remainder with a done flag and sits beside the multiplier in the arithmetic unit.

Parameters:
WIDTH, 16, operand, quotient and remainder width in bits

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  begin operation; sampled only in IDLE or DONE
data_in  input  WIDTH  shared operand bus: dividend in LOAD_A, divisor in LOAD_B
busy  output  1  high in LOAD_A, LOAD_B, CHECK and SUB
done  output  1  high while in DONE; results valid
div_by_zero  output  1  high in DONE when the captured divisor was 0
quotient  output  WIDTH  quotient register (Q)
remainder  output  WIDTH  running remainder register (R)

Behaviour:
- Reset (rst_n low, asynchronous, any state, including mid-operation):
  - state=IDLE; Q, R and divisor register D = 0.
  - busy=0, done=0, div_by_zero=0.
  - The first rising edge after rst_n rises behaves as in IDLE.
- All outputs are decoded from registered state/registers; there are no combinational paths from inputs to outputs.
- States: IDLE, LOAD_A, LOAD_B, CHECK, SUB, DONE.
- IDLE: start=1 at an edge -> LOAD_A.
- LOAD_A: edge captures R<=data_in (dividend) -> LOAD_B.
- LOAD_B: edge captures D<=data_in (divisor), Q<=0 -> CHECK.
- CHECK:
  - D==0: Q<=all ones, R unchanged (=dividend), div_by_zero<=1 -> DONE.
  - Otherwise -> SUB.
- SUB, each edge:
  - R>=D: R<=R-D, Q<=Q+1, stay in SUB.
  - R<D: -> DONE with Q and R unchanged.
- Arithmetic: unsigned WIDTH-bit only. The compare is a full unsigned >=. The subtraction never underflows; Q cannot overflow because Q <= dividend.
- DONE:
  - done=1; Q and R hold; outputs remain stable indefinitely.
  - start=1 -> LOAD_A; done and div_by_zero clear on that edge.
  - No extra IDLE cycle is needed for back-to-back operations.
- div_by_zero is cleared on entry to LOAD_A and set only in CHECK.
- start while busy: ignored, with no effect on state or registers.
- Latency: counting the edge that samples start as edge 0, done is high after edge Q+4 (LOAD_A, LOAD_B, CHECK, then Q+1 SUB edges). Divide-by-zero: done after edge 3.
- Boundary cases:
  - dividend=0 -> Q=0, R=0, one SUB cycle.
  - dividend<divisor -> Q=0, R=dividend.
  - dividend==divisor -> Q=1, R=0.
  - divisor=1, dividend=0xFFFF -> Q=0xFFFF after 65536 SUB edges.
- Intermediate Q/R values are visible during SUB. Consumers must qualify them with done.
- data_in is sampled only at the LOAD_A and LOAD_B edges and is don't-care otherwise.

Test Plan:
- Reset then start, dividend 100, divisor 7 -> done after edge 18; Q=14, R=2, div_by_zero=0; busy=1 from edge 1 through edge 17.
- Dividend 3/divisor 10, 0/5 and 9/9 -> (Q,R) = (0,3), (0,0), (1,0); done after edges 4, 4 and 5 respectively.
- Dividend 1234, divisor 0 -> done after edge 3; div_by_zero=1, Q=0xFFFF, R=1234. Next start with 10/3 -> div_by_zero clears on LOAD_A; result Q=3, R=1.
- Start pulsed repeatedly during SUB of 50/1 -> ignored; Q=50, R=0. Then start is asserted while in DONE with 0xFFFF/1 -> back-to-back run; Q=0xFFFF, R=0 after 65540 edges.
- rst_n driven low mid-SUB of 200/3, asynchronously between edges -> state, busy, Q and R go to 0 immediately. A new 200/3 run completes with Q=66, R=2.
- Random 200 operand pairs, divisor non-zero -> Q*divisor+R==dividend, R<divisor, latency==Q+4 edges; compare against a reference model.

Source files
------------

// File: rtl/repeat_sub_divider.sv
// Unsigned repeated-subtraction divider. Dividend and divisor arrive on the
// shared data_in bus on the two edges after start. Quotient and remainder
// are valid while done is high.
module repeat_sub_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        CHECK  = 3'd3,
        SUB    = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_r, r_r, d_r;
    logic [WIDTH-1:0] q_nxt, r_nxt, d_nxt;
    logic             dbz_r, dbz_nxt;
    logic             r_ge_d;

    // Full unsigned compare; the subtraction is only taken when it holds,
    // so R never underflows.
    assign r_ge_d = (r_r >= d_r);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and datapath control; every register holds by default.
    always_comb begin
        state_nxt = state;
        q_nxt     = q_r;
        r_nxt     = r_r;
        d_nxt     = d_r;
        dbz_nxt   = dbz_r;
        case (state)
            IDLE, DONE: begin
                // A new run may start straight out of DONE; the stale
                // divide-by-zero flag drops as LOAD_A is entered.
                if (start) begin
                    state_nxt = LOAD_A;
                    dbz_nxt   = 1'b0;
                end
            end
            LOAD_A: begin
                r_nxt     = data_in;
                state_nxt = LOAD_B;
            end
            LOAD_B: begin
                d_nxt     = data_in;
                q_nxt     = '0;
                state_nxt = CHECK;
            end
            CHECK: begin
                if (d_r == '0) begin
                    // Saturated quotient, dividend left in R.
                    q_nxt     = '1;
                    dbz_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    state_nxt = SUB;
                end
            end
            SUB: begin
                if (r_ge_d) begin
                    r_nxt = r_r - d_r;
                    q_nxt = q_r + WIDTH'(1);
                end else begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r   <= '0;
            r_r   <= '0;
            d_r   <= '0;
            dbz_r <= 1'b0;
        end else begin
            q_r   <= q_nxt;
            r_r   <= r_nxt;
            d_r   <= d_nxt;
            dbz_r <= dbz_nxt;
        end
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        busy        = (state == LOAD_A) || (state == LOAD_B) ||
                      (state == CHECK)  || (state == SUB);
        done        = (state == DONE);
        div_by_zero = dbz_r;
        quotient    = q_r;
        remainder   = r_r;
    end

endmodule

// File: tb/tb_repeat_sub_divider.sv
// Directed-vector and corner-sequence bench for repeat_sub_divider.
module tb_repeat_sub_divider;

    localparam int W      = 16;
    localparam int BUDGET = 70000;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] data_in;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int errors = 0;
    int checks = 0;

    repeat_sub_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .data_in     (data_in),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called #1 after an edge with the DUT in IDLE or DONE. Returns #1
    // after edge 2 (divisor captured).
    task automatic start_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        @(posedge clk); #1;              // edge 0
        start = 1'b0;
        chk({nm, " busy@e0"}, busy, 1);
        chk({nm, " done@e0"}, done, 0);
        chk({nm, " dbz@e0"}, div_by_zero, 0);
        data_in = a;
        @(posedge clk); #1;              // edge 1
        data_in = b;
        @(posedge clk); #1;              // edge 2
        data_in = W'($urandom);
    endtask

    // Counts edges until done; every cycle before that must show busy.
    task automatic wait_done(input string nm, input bit pulse, output int lat);
        int  e   = 2;
        int  bad = 0;
        bit  ok  = 0;
        while (e < BUDGET) begin
            @(posedge clk); #1;
            e++;
            if (done) begin
                ok = 1;
                break;
            end
            if (!busy) bad++;
            if (pulse) start = e[0];
        end
        start = 1'b0;
        chk({nm, " busy-run"}, bad, 0);
        chk({nm, " done-seen"}, {31'b0, ok}, 1);
        lat = e;
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edbz, input int elat, input bit pulse);
        int lat;
        start_op(nm, a, b);
        wait_done(nm, pulse, lat);
        chk({nm, " Q"}, {16'b0, quotient}, {16'b0, eq});
        chk({nm, " R"}, {16'b0, remainder}, {16'b0, er});
        chk({nm, " dbz"}, {31'b0, div_by_zero}, {31'b0, edbz});
        chk({nm, " busy@done"}, {31'b0, busy}, 0);
        chk({nm, " latency"}, lat, elat);
    endtask

    initial begin
        int           lat;
        logic [W-1:0] ra, rb;

        tbl[0] = '{a: 16'd100,   b: 16'd7,     q: 16'd14,    r: 16'd2,     dbz: 1'b0, lat: 18};
        tbl[1] = '{a: 16'd3,     b: 16'd10,    q: 16'd0,     r: 16'd3,     dbz: 1'b0, lat: 4};
        tbl[2] = '{a: 16'd0,     b: 16'd5,     q: 16'd0,     r: 16'd0,     dbz: 1'b0, lat: 4};
        tbl[3] = '{a: 16'd9,     b: 16'd9,     q: 16'd1,     r: 16'd0,     dbz: 1'b0, lat: 5};
        tbl[4] = '{a: 16'd1234,  b: 16'd0,     q: 16'hFFFF,  r: 16'd1234,  dbz: 1'b1, lat: 3};
        tbl[5] = '{a: 16'd10,    b: 16'd3,     q: 16'd3,     r: 16'd1,     dbz: 1'b0, lat: 7};
        tbl[6] = '{a: 16'hFFFF,  b: 16'hFFFF,  q: 16'd1,     r: 16'd0,     dbz: 1'b0, lat: 5};
        tbl[7] = '{a: 16'hFFFE,  b: 16'hFFFF,  q: 16'd0,     r: 16'hFFFE,  dbz: 1'b0, lat: 4};
        tbl[8] = '{a: 16'd1000,  b: 16'd250,   q: 16'd4,     r: 16'd0,     dbz: 1'b0, lat: 8};

        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        #12;
        chk("reset busy", {31'b0, busy}, 0);
        chk("reset done", {31'b0, done}, 0);
        chk("reset dbz", {31'b0, div_by_zero}, 0);
        chk("reset Q", {16'b0, quotient}, 0);
        chk("reset R", {16'b0, remainder}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table runs back to back; all but the first start from DONE.
        for (int i = 0; i < 9; i++)
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r,
                   tbl[i].dbz, tbl[i].lat, 1'b0);

        // start toggled throughout SUB must be ignored.
        run_op("ign50/1", 16'd50, 16'd1, 16'd50, 16'd0, 1'b0, 54, 1'b1);
        // Immediate back-to-back from DONE with the longest run.
        run_op("max/1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 65539, 1'b0);

        // Asynchronous reset between edges in the middle of SUB.
        start_op("rst200/3", 16'd200, 16'd3);
        repeat (6) @(posedge clk);
        #4;
        chk("pre-rst busy", {31'b0, busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("async busy", {31'b0, busy}, 0);
        chk("async done", {31'b0, done}, 0);
        chk("async Q", {16'b0, quotient}, 0);
        chk("async R", {16'b0, remainder}, 0);
        #13;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-rst idle", {31'b0, busy}, 0);
        run_op("re200/3", 16'd200, 16'd3, 16'd66, 16'd2, 1'b0, 70, 1'b0);

        // Random pairs with quotient kept small to bound run time.
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            rb = W'($urandom_range(1, 16'hFFFF));
            if (ra / rb > 40) rb = ra / 40 + 16'd1;
            run_op($sformatf("rnd%0d", i), ra, rb, ra / rb, ra % rb, 1'b0,
                   int'(ra / rb) + 4, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
